// File: rtl/video_timing_gen.sv
// Video timing generator: free-running raster counters, registered sync/DE outputs,
// and a test-pattern / upstream-stream pixel source selected once per frame.
module video_timing_gen #(
    parameter int   HDISP     = 800,
    parameter int   VDISP     = 480,
    parameter int   HFP       = 40,
    parameter int   HPULSE    = 48,
    parameter int   HBP       = 40,
    parameter int   VFP       = 13,
    parameter int   VPULSE    = 3,
    parameter int   VBP       = 29,
    parameter logic HS_POL    = 1'b0,
    parameter logic VS_POL    = 1'b0,
    parameter int   GRID_LOG2 = 4
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst,
    input  logic [1:0]  mode,
    input  logic [23:0] solid_rgb,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    output logic        pix_ready,
    output logic        hs,
    output logic        vs,
    output logic        de,
    output logic [23:0] rgb,
    output logic        frame_start,
    output logic        underflow,
    input  logic        underflow_clr
);

    localparam int HTOTAL = HFP + HPULSE + HBP + HDISP;
    localparam int VTOTAL = VFP + VPULSE + VBP + VDISP;
    localparam int HW     = $clog2(HTOTAL);
    localparam int VW     = $clog2(VTOTAL);
    localparam int BAR_W  = (HDISP / 8 > 0) ? HDISP / 8 : 1;

    localparam logic [HW-1:0] H_LAST  = HW'(HTOTAL - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(VTOTAL - 1);
    localparam logic [HW-1:0] H_SYNC0 = HW'(HFP);
    localparam logic [HW-1:0] H_SYNC1 = HW'(HFP + HPULSE);
    localparam logic [HW-1:0] H_START = HW'(HFP + HPULSE + HBP);
    localparam logic [VW-1:0] V_SYNC0 = VW'(VFP);
    localparam logic [VW-1:0] V_SYNC1 = VW'(VFP + VPULSE);
    localparam logic [VW-1:0] V_START = VW'(VFP + VPULSE + VBP);
    localparam logic [HW-1:0] BAR_WL  = HW'(BAR_W);

    logic [HW-1:0] hcnt_q, hcnt_d;
    logic [VW-1:0] vcnt_q, vcnt_d;
    logic [1:0]    mode_q, mode_d;
    logic [23:0]   solid_q, solid_d;
    logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic [23:0]   rgb_q, rgb_d;
    logic          frame_start_q, frame_start_d;
    logic          underflow_q, underflow_d;

    logic                 active, frame_top, underflow_set;
    logic [HW-1:0]        x, bar_idx;
    logic [2:0]           bar_sel;
    logic [GRID_LOG2-1:0] x_lo, y_lo;

    function automatic logic [23:0] bar_colour(input logic [2:0] b);
        case (b)
            3'd0:    bar_colour = 24'hFFFFFF;
            3'd1:    bar_colour = 24'hFFFF00;
            3'd2:    bar_colour = 24'h00FFFF;
            3'd3:    bar_colour = 24'h00FF00;
            3'd4:    bar_colour = 24'hFF00FF;
            3'd5:    bar_colour = 24'hFF0000;
            3'd6:    bar_colour = 24'h0000FF;
            default: bar_colour = 24'h000000;
        endcase
    endfunction

    always_comb begin
        hcnt_d = hcnt_q + HW'(1);
        vcnt_d = vcnt_q;
        if (hcnt_q == H_LAST) begin
            hcnt_d = '0;
            vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + VW'(1);
        end
    end

    assign active    = (hcnt_q >= H_START) && (vcnt_q >= V_START);
    assign frame_top = (hcnt_q == '0) && (vcnt_q == '0);
    assign x         = hcnt_q - H_START;
    assign x_lo      = GRID_LOG2'(hcnt_q - H_START);
    assign y_lo      = GRID_LOG2'(vcnt_q - V_START);
    assign bar_idx   = x / BAR_WL;
    // The last bar soaks up the HDISP % 8 leftover pixels.
    assign bar_sel   = (bar_idx >= HW'(7)) ? 3'd7 : bar_idx[2:0];

    assign pix_ready     = active && (mode_q == 2'd3);
    assign underflow_set = pix_ready && !pix_valid;

    always_comb begin
        mode_d        = frame_top ? mode      : mode_q;
        solid_d       = frame_top ? solid_rgb : solid_q;
        hs_d          = (hcnt_q >= H_SYNC0 && hcnt_q < H_SYNC1) ? HS_POL : ~HS_POL;
        vs_d          = (vcnt_q >= V_SYNC0 && vcnt_q < V_SYNC1) ? VS_POL : ~VS_POL;
        de_d          = active;
        frame_start_d = frame_top;
        rgb_d         = 24'h000000;
        if (active) begin
            case (mode_q)
                2'd0:    rgb_d = (x_lo == '0 || y_lo == '0) ? 24'hFFFFFF : 24'h000000;
                2'd1:    rgb_d = bar_colour(bar_sel);
                2'd2:    rgb_d = solid_q;
                default: rgb_d = pix_valid ? pix_data : 24'h000000;
            endcase
        end
        underflow_d = underflow_set ? 1'b1 : (underflow_clr ? 1'b0 : underflow_q);
    end

    always_ff @(posedge pixel_clk or posedge pixel_rst) begin
        if (pixel_rst) begin
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            mode_q        <= 2'd0;
            solid_q       <= 24'h000000;
            hs_q          <= ~HS_POL;
            vs_q          <= ~VS_POL;
            de_q          <= 1'b0;
            rgb_q         <= 24'h000000;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            mode_q        <= mode_d;
            solid_q       <= solid_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            de_q          <= de_d;
            rgb_q         <= rgb_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign rgb         = rgb_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;

endmodule
